// File: rtl/alu_pkg.sv
// Shared constants for the vector ALU execute stage: opcodes, function
// codes, lane-width encodings and the EX state machine encoding.
package alu_pkg;

    localparam logic [0:5] R_OPCODE = 6'b101010;

    localparam logic [0:5] VAND   = 6'b000001;
    localparam logic [0:5] VOR    = 6'b000010;
    localparam logic [0:5] VXOR   = 6'b000011;
    localparam logic [0:5] VNOT   = 6'b000100;
    localparam logic [0:5] VMOV   = 6'b000101;
    localparam logic [0:5] VADD   = 6'b000110;
    localparam logic [0:5] VSUB   = 6'b000111;
    localparam logic [0:5] VMULEU = 6'b001000;
    localparam logic [0:5] VMULOU = 6'b001001;
    localparam logic [0:5] VSLL   = 6'b001010;
    localparam logic [0:5] VSRL   = 6'b001011;
    localparam logic [0:5] VSRA   = 6'b001100;
    localparam logic [0:5] VRTTH  = 6'b001101;
    localparam logic [0:5] VDIV   = 6'b001110;
    localparam logic [0:5] VMOD   = 6'b001111;
    localparam logic [0:5] VSQEU  = 6'b010000;
    localparam logic [0:5] VSQOU  = 6'b010001;
    localparam logic [0:5] VSQRT  = 6'b010010;

    localparam logic [0:1] WW_8  = 2'b00;
    localparam logic [0:1] WW_16 = 2'b01;
    localparam logic [0:1] WW_32 = 2'b10;
    localparam logic [0:1] WW_64 = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MC_WAIT = 2'd1,
        EXEC    = 2'd2
    } ex_state_e;

    // Functions whose combinational ALU path needs extra settling cycles.
    function automatic logic is_mc_func(input logic [0:5] f);
        return (f == VDIV) || (f == VMOD) || (f == VSQRT);
    endfunction

endpackage

// File: rtl/alu_ex_stage_fwd_mux.sv
// Priority operand select: EX result, then result slot, then write-back,
// then register file. Register 0 always reads the register file.
module ex_fwd_mux #(
    parameter int AW = 5
) (
    input  logic [0:AW-1] addr_i,
    input  logic          ex_en_i,
    input  logic [0:AW-1] ex_rd_i,
    input  logic [0:63]   ex_data_i,
    input  logic          slot_en_i,
    input  logic [0:AW-1] slot_rd_i,
    input  logic [0:63]   slot_data_i,
    input  logic          wb_en_i,
    input  logic [0:AW-1] wb_rd_i,
    input  logic [0:63]   wb_data_i,
    input  logic [0:63]   rf_data_i,
    output logic [0:63]   data_o
);

    logic nz;
    logic ex_hit, slot_hit, wb_hit;

    assign nz       = |addr_i;
    assign ex_hit   = nz && ex_en_i && (ex_rd_i == addr_i);
    assign slot_hit = nz && slot_en_i && (slot_rd_i == addr_i);
    assign wb_hit   = nz && wb_en_i && (wb_rd_i == addr_i);

    always_comb begin
        data_o = rf_data_i;
        if (ex_hit) begin
            data_o = ex_data_i;
        end else if (slot_hit) begin
            data_o = slot_data_i;
        end else if (wb_hit) begin
            data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Vector ALU execute stage: ID/EX register with forwarding, multi-cycle
// settling for slow functions, and one EX/WB result slot (valid/ready).
module alu_ex_stage #(
    parameter int         MC_LAT   = 4,
    parameter logic [0:5] R_OPCODE = alu_pkg::R_OPCODE,
    parameter int         AW       = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [0:5]    in_opcode,
    input  logic [0:5]    in_func,
    input  logic [0:1]    in_ww,
    input  logic [0:AW-1] in_ra_addr,
    input  logic [0:AW-1] in_rb_addr,
    input  logic [0:AW-1] in_rd_addr,
    input  logic          in_wr_en,
    input  logic [0:63]   in_ra_data,
    input  logic [0:63]   in_rb_data,
    input  logic          wb_wr_en,
    input  logic [0:AW-1] wb_rd_addr,
    input  logic [0:63]   wb_data,
    output logic [0:63]   alu_ra,
    output logic [0:63]   alu_rb,
    output logic [0:5]    alu_func,
    output logic [0:5]    alu_opcode,
    output logic [0:1]    alu_ww,
    input  logic [0:63]   alu_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:63]   out_data,
    output logic [0:AW-1] out_rd_addr,
    output logic          out_wr_en,
    output logic          busy
);

    import alu_pkg::*;

    localparam int CW = $clog2(MC_LAT + 1);

    ex_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:63]   ra_q, rb_q;
    logic [0:5]    func_q, opcode_q;
    logic [0:1]    ww_q;
    logic [0:AW-1] rd_q;
    logic          wr_en_q;
    logic          busy_q;
    logic          out_valid_q;
    logic          out_wr_en_q;
    logic [0:63]   out_data_q;
    logic [0:AW-1] out_rd_q;

    logic          slot_free;
    logic          retire;
    logic          accept;
    logic          is_r;
    logic          is_mc;
    logic          ex_fwd_en;
    logic          slot_fwd_en;
    logic [0:63]   fwd_a, fwd_b;

    assign slot_free = !out_valid_q || out_ready;
    assign retire    = (state_q == EXEC) && slot_free;
    assign in_ready  = (state_q == IDLE) || retire;
    assign accept    = in_valid && in_ready;
    assign is_r      = (in_opcode == R_OPCODE);
    assign is_mc     = is_r && is_mc_func(in_func);

    assign ex_fwd_en   = retire && wr_en_q;
    assign slot_fwd_en = out_valid_q && out_wr_en_q;

    ex_fwd_mux #(.AW(AW)) u_fwd_a (
        .addr_i      (in_ra_addr),
        .ex_en_i     (ex_fwd_en),
        .ex_rd_i     (rd_q),
        .ex_data_i   (alu_out),
        .slot_en_i   (slot_fwd_en),
        .slot_rd_i   (out_rd_q),
        .slot_data_i (out_data_q),
        .wb_en_i     (wb_wr_en),
        .wb_rd_i     (wb_rd_addr),
        .wb_data_i   (wb_data),
        .rf_data_i   (in_ra_data),
        .data_o      (fwd_a)
    );

    ex_fwd_mux #(.AW(AW)) u_fwd_b (
        .addr_i      (in_rb_addr),
        .ex_en_i     (ex_fwd_en),
        .ex_rd_i     (rd_q),
        .ex_data_i   (alu_out),
        .slot_en_i   (slot_fwd_en),
        .slot_rd_i   (out_rd_q),
        .slot_data_i (out_data_q),
        .wb_en_i     (wb_wr_en),
        .wb_rd_i     (wb_rd_addr),
        .wb_data_i   (wb_data),
        .rf_data_i   (in_rb_data),
        .data_o      (fwd_b)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, EXEC: begin
                if (accept) begin
                    if (is_mc) begin
                        state_d = MC_WAIT;
                        cnt_d   = CW'(MC_LAT - 1);
                    end else begin
                        state_d = EXEC;
                    end
                end else if (retire) begin
                    state_d = IDLE;
                end
            end
            MC_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            func_q      <= '0;
            opcode_q    <= '0;
            ww_q        <= '0;
            rd_q        <= '0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_wr_en_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
            if (accept) begin
                ra_q     <= fwd_a;
                rb_q     <= fwd_b;
                func_q   <= in_func;
                opcode_q <= in_opcode;
                ww_q     <= in_ww;
                rd_q     <= in_rd_addr;
                // Non-R-type instructions pass through as NOPs.
                wr_en_q  <= in_wr_en && is_r;
            end
            if (retire) begin
                out_valid_q <= 1'b1;
                out_data_q  <= alu_out;
                out_rd_q    <= rd_q;
                out_wr_en_q <= wr_en_q;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign alu_ra      = ra_q;
    assign alu_rb      = rb_q;
    assign alu_func    = func_q;
    assign alu_opcode  = opcode_q;
    assign alu_ww      = ww_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_rd_addr = out_rd_q;
    assign out_wr_en   = out_wr_en_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage; the bench itself plays the ALU.
module tb_alu_ex_stage;

    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode, in_func;
    logic [1:0]  in_ww;
    logic [4:0]  in_ra_addr, in_rb_addr, in_rd_addr;
    logic        in_wr_en;
    logic [63:0] in_ra_data, in_rb_data;
    logic        wb_wr_en;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_data;
    logic [63:0] alu_ra, alu_rb;
    logic [5:0]  alu_func, alu_opcode;
    logic [1:0]  alu_ww;
    logic [63:0] alu_out;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd_addr;
    logic        out_wr_en;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] ROP = 6'b101010;

    always #5 clk = ~clk;

    alu_ex_stage #(.MC_LAT(4), .R_OPCODE(6'b101010), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_func(in_func), .in_ww(in_ww),
        .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
        .in_rd_addr(in_rd_addr), .in_wr_en(in_wr_en),
        .in_ra_data(in_ra_data), .in_rb_data(in_rb_data),
        .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .alu_ra(alu_ra), .alu_rb(alu_rb),
        .alu_func(alu_func), .alu_opcode(alu_opcode), .alu_ww(alu_ww),
        .alu_out(alu_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd_addr(out_rd_addr),
        .out_wr_en(out_wr_en), .busy(busy)
    );

    function automatic logic [63:0] lane_add(
        input logic [63:0] a, input logic [63:0] b, input logic [1:0] ww);
        logic [63:0] s;
        logic        c;
        int          l;
        l = 8 << ww;
        c = 1'b0;
        s = '0;
        for (int i = 0; i < 64; i++) begin
            if (i % l == 0) c = 1'b0;
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return s;
    endfunction

    always_comb begin
        alu_out = alu_ra;
        if (alu_func == VAND) alu_out = alu_ra & alu_rb;
        else if (alu_func == VOR) alu_out = alu_ra | alu_rb;
        else if (alu_func == VXOR) alu_out = alu_ra ^ alu_rb;
        else if (alu_func == VADD) alu_out = lane_add(alu_ra, alu_rb, alu_ww);
        else if (alu_func == VDIV) alu_out = (alu_rb != 0) ? alu_ra / alu_rb : '0;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] opc, input logic [5:0] f,
                         input logic [1:0] ww, input logic [4:0] ra_a,
                         input logic [4:0] rb_a, input logic [4:0] rd_a,
                         input logic [63:0] ra_d, input logic [63:0] rb_d);
        in_valid   = 1'b1;
        in_opcode  = opc;
        in_func    = f;
        in_ww      = ww;
        in_ra_addr = ra_a;
        in_rb_addr = rb_a;
        in_rd_addr = rd_a;
        in_wr_en   = 1'b1;
        in_ra_data = ra_d;
        in_rb_data = rb_d;
    endtask

    // Slot holds rd=r with AA..AA while WB writes r with 55..55.
    task automatic fwd_case(input logic [4:0] r, input logic [63:0] rf,
                            input logic [63:0] exp, input string tag);
        out_ready = 1'b0;
        issue(ROP, VOR, 2'b11, 5'd1, 5'd2, r, {16{4'hA}}, 64'h0);
        tick();
        in_valid = 1'b0;
        tick();
        check({tag, "_slot_valid"}, 64'(out_valid), 64'd1);
        wb_wr_en   = 1'b1;
        wb_rd_addr = r;
        wb_data    = {16{4'h5}};
        issue(ROP, VOR, 2'b11, r, 5'd0, 5'd9, rf, 64'h0);
        tick();
        in_valid = 1'b0;
        wb_wr_en = 1'b0;
        check({tag, "_opnd"}, alu_ra, exp);
        out_ready = 1'b1;
        tick();
        tick();
        check({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_opcode = '0; in_func = '0; in_ww = '0;
        in_ra_addr = '0; in_rb_addr = '0; in_rd_addr = '0;
        in_wr_en = 1'b0; in_ra_data = '0; in_rb_data = '0;
        wb_wr_en = 1'b0; wb_rd_addr = '0; wb_data = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_rd", 64'(out_rd_addr), 64'd0);
        check("rst_out_wr_en", 64'(out_wr_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_alu_ra", alu_ra, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // VADD with byte lanes
        issue(ROP, VADD, 2'b00, 5'd1, 5'd2, 5'd3,
              64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111);
        #1 check("t1_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_no_valid_yet", 64'(out_valid), 64'd0);
        tick();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data", out_data, 64'hFFFFFFFF_10101010);
        check("t1_rd", 64'(out_rd_addr), 64'd3);
        check("t1_wr_en", 64'(out_wr_en), 64'd1);
        tick();
        check("t1_drained", 64'(out_valid), 64'd0);
        check("t1_idle", 64'(busy), 64'd0);

        // back-to-back dependency through alu_out
        issue(ROP, VAND, 2'b11, 5'd1, 5'd2, 5'd3, 64'd15, 64'd14);
        tick();
        issue(ROP, VOR, 2'b11, 5'd3, 5'd5, 5'd4, 64'd0, 64'd1);
        #1 check("t2_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("t2_first", out_data, 64'd14);
        check("t2_fwd_opnd", alu_ra, 64'd14);
        tick();
        check("t2_second", out_data, 64'd15);
        check("t2_second_rd", 64'(out_rd_addr), 64'd4);
        tick();

        // multi-cycle VDIV then VAND
        issue(ROP, VDIV, 2'b11, 5'd1, 5'd2, 5'd6, 64'd100, 64'd7);
        tick();
        issue(ROP, VAND, 2'b11, 5'd9, 5'd10, 5'd8, 64'hF0, 64'h3C);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_stall_ready", 64'(in_ready), 64'd0);
            check("t3_busy", 64'(busy), 64'd1);
            check("t3_no_valid", 64'(out_valid), 64'd0);
            tick();
        end
        check("t3_exec_ready", 64'(in_ready), 64'd1);
        check("t3_not_yet", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        check("t3_div_valid", 64'(out_valid), 64'd1);
        check("t3_div_data", out_data, 64'd14);
        check("t3_div_rd", 64'(out_rd_addr), 64'd6);
        tick();
        check("t3_and_data", out_data, 64'h30);
        check("t3_and_rd", 64'(out_rd_addr), 64'd8);
        tick();

        // backpressure with two queued VADDs
        out_ready = 1'b0;
        issue(ROP, VADD, 2'b11, 5'd1, 5'd2, 5'd11, 64'd1, 64'd2);
        tick();
        issue(ROP, VADD, 2'b11, 5'd1, 5'd2, 5'd12, 64'd10, 64'd20);
        #1 check("t4_accept2", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_hold_valid", 64'(out_valid), 64'd1);
            check("t4_hold_data", out_data, 64'd3);
            check("t4_hold_ready", 64'(in_ready), 64'd0);
            check("t4_hold_opnd", alu_ra, 64'd10);
            tick();
        end
        out_ready = 1'b1;
        #1 check("t4_release_ready", 64'(in_ready), 64'd1);
        tick();
        check("t4_second_valid", 64'(out_valid), 64'd1);
        check("t4_second_data", out_data, 64'd30);
        check("t4_second_rd", 64'(out_rd_addr), 64'd12);
        tick();
        check("t4_empty", 64'(out_valid), 64'd0);

        // forwarding priority
        fwd_case(5'd7, 64'h0, {16{4'hA}}, "t5_slot_over_wb");
        fwd_case(5'd0, 64'h1234, 64'h1234, "t5_r0");
        wb_wr_en   = 1'b1;
        wb_rd_addr = 5'd13;
        wb_data    = {16{4'h5}};
        issue(ROP, VOR, 2'b11, 5'd13, 5'd0, 5'd9, 64'h0, 64'h0);
        tick();
        in_valid = 1'b0;
        wb_wr_en = 1'b0;
        check("t5_wb_opnd", alu_ra, {16{4'h5}});
        tick();
        tick();

        // reset during MC_WAIT
        issue(ROP, VDIV, 2'b11, 5'd1, 5'd2, 5'd6, 64'd100, 64'd7);
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_opnd", alu_ra, 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("t6_no_result", 64'(out_valid), 64'd0);
            tick();
        end
        check("t6_ready", 64'(in_ready), 64'd1);
        issue(ROP, VXOR, 2'b11, 5'd1, 5'd2, 5'd2, 64'd15, 64'd14);
        tick();
        in_valid = 1'b0;
        tick();
        check("t6_xor_valid", 64'(out_valid), 64'd1);
        check("t6_xor_data", out_data, 64'd1);
        tick();

        // non-R opcode is a NOP
        issue(6'b000000, VADD, 2'b11, 5'd1, 5'd2, 5'd5, 64'd1, 64'd1);
        tick();
        in_valid = 1'b0;
        tick();
        check("nop_valid", 64'(out_valid), 64'd1);
        check("nop_wr_en", 64'(out_wr_en), 64'd0);
        check("nop_data", out_data, 64'd2);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
